// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - MD op encoding, default latencies and HI/LO result select
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MFHI  = 3'd6,
    OP_MFLO  = 3'd7
  } mdu_op_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // E-stage result mux: HI for MFHI, LO for MFLO, zero otherwise.
  function automatic logic [31:0] hilo_sel(input mdu_op_e op,
                                           input logic [31:0] hi,
                                           input logic [31:0] lo);
    case (op)
      OP_MFHI: return hi;
      OP_MFLO: return lo;
      default: return 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/mdu_unit.sv
// rtl/mdu_unit.sv - multi-cycle MULT/DIV unit holding HI/LO; MDU_TRACE_EN enables HI/LO write trace
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [31:0] PC,
  output logic        busy,
  output logic [31:0] rdata
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [31:0]      hi, lo, hi_n, lo_n;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  logic [63:0]        prod_s, prod_u;
  logic signed [31:0] sa, sb, q_s, r_s;
  logic [31:0]        dsor_u, q_u, r_u;
  logic [31:0]        res_hi, res_lo;

  assign busy   = (cnt != '0);
  assign accept = start && !busy;
  assign rdata  = hilo_sel(mdu_op_e'(op), hi, lo);

  // Divisor is forced non-zero so the datapath never sees x; B==0 keeps HI/LO below.
  always_comb begin
    prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    prod_u = {32'h0, A} * {32'h0, B};
    sa     = A;
    sb     = (B == 32'h0) ? 32'sd1 : $signed(B);
    dsor_u = (B == 32'h0) ? 32'd1 : B;
    if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
      q_s = $signed(32'h8000_0000);
      r_s = 32'sd0;
    end else begin
      q_s = sa / sb;
      r_s = sa % sb;
    end
    q_u = A / dsor_u;
    r_u = A % dsor_u;

    res_hi = hi;
    res_lo = lo;
    case (mdu_op_e'(op))
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV:   if (B != 32'h0) begin res_hi = r_s; res_lo = q_s; end
      OP_DIVU:  if (B != 32'h0) begin res_hi = r_u; res_lo = q_u; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi   <= '0;
      lo   <= '0;
      hi_n <= '0;
      lo_n <= '0;
      cnt  <= '0;
    end else if (busy) begin
      if (cnt == CNT_W'(1)) begin
        hi  <= hi_n;
        lo  <= lo_n;
        cnt <= '0;
      end else begin
        cnt <= cnt - CNT_W'(1);
      end
    end else if (start) begin
      case (mdu_op_e'(op))
        OP_MULT, OP_MULTU: begin
          hi_n <= res_hi;
          lo_n <= res_lo;
          cnt  <= CNT_W'(MULT_CYCLES);
        end
        OP_DIV, OP_DIVU: begin
          hi_n <= res_hi;
          lo_n <= res_lo;
          cnt  <= CNT_W'(DIV_CYCLES);
        end
        OP_MTHI: hi <= A;
        OP_MTLO: lo <= A;
        default: ;
      endcase
    end
  end

`ifdef MDU_TRACE_EN
  logic [31:0] pc_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      pc_q <= '0;
    else if (accept && !op[2])
      pc_q <= PC;
  end

  // Same line format as the register-file write trace.
  always @(posedge clk) begin
    if (reset) begin
      if (cnt == CNT_W'(1)) begin
        $display("%0t: PC=0x%08h hi <= 0x%08h", $time, pc_q, hi_n);
        $display("%0t: PC=0x%08h lo <= 0x%08h", $time, pc_q, lo_n);
      end else if (accept && mdu_op_e'(op) == OP_MTHI) begin
        $display("%0t: PC=0x%08h hi <= 0x%08h", $time, PC, A);
      end else if (accept && mdu_op_e'(op) == OP_MTLO) begin
        $display("%0t: PC=0x%08h lo <= 0x%08h", $time, PC, A);
      end
    end
  end
`endif

endmodule

// File: tb/tb_mdu_unit.sv
// tb/tb_mdu_unit.sv - directed self-checking bench for mdu_unit
module tb_mdu_unit;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A, B, PC;
  logic        busy;
  logic [31:0] rdata;

  int checks = 0;
  int failures = 0;
  int n;

  mdu_unit dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .PC    (PC),
    .busy  (busy),
    .rdata (rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic chk_rd(input string tag, input logic [2:0] o, input logic [31:0] exp);
    op = o;
    #1;
    chk(tag, rdata, exp);
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    A     = a;
    B     = b;
    PC    = PC + 32'd4;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic busy_cycles(output int cyc);
    cyc = 0;
    @(negedge clk);
    while (busy && cyc < 40) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    op    = OP_MFHI;
    A     = '0;
    B     = '0;
    PC    = 32'h0000_3000;
    #12;
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk_rd("reset_hi", OP_MFHI, 32'h0);
    chk_rd("reset_lo", OP_MFLO, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    issue(OP_MULT, 32'hFFFF_FFFE, 32'd3);
    busy_cycles(n);
    chk("mult_busy", n, 5);
    chk_rd("mult_hi", OP_MFHI, 32'hFFFF_FFFF);
    chk_rd("mult_lo", OP_MFLO, 32'hFFFF_FFFA);

    issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    busy_cycles(n);
    chk("multu_busy", n, 5);
    chk_rd("multu_hi", OP_MFHI, 32'h0000_0001);
    chk_rd("multu_lo", OP_MFLO, 32'hFFFF_FFFE);

    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    busy_cycles(n);
    chk("div_busy", n, 10);
    chk_rd("div_hi", OP_MFHI, 32'hFFFF_FFFF);
    chk_rd("div_lo", OP_MFLO, 32'hFFFF_FFFD);

    issue(OP_DIVU, 32'd7, 32'd0);
    busy_cycles(n);
    chk("div0_busy", n, 10);
    chk_rd("div0_hi", OP_MFHI, 32'hFFFF_FFFF);
    chk_rd("div0_lo", OP_MFLO, 32'hFFFF_FFFD);

    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    busy_cycles(n);
    chk_rd("divovf_hi", OP_MFHI, 32'h0);
    chk_rd("divovf_lo", OP_MFLO, 32'h8000_0000);

    issue(OP_DIV, 32'd7, 32'hFFFF_FFFE);
    busy_cycles(n);
    chk_rd("divneg_hi", OP_MFHI, 32'h0000_0001);
    chk_rd("divneg_lo", OP_MFLO, 32'hFFFF_FFFD);

    issue(OP_DIVU, 32'hFFFF_FFF9, 32'd2);
    busy_cycles(n);
    chk_rd("divu_hi", OP_MFHI, 32'h0000_0001);
    chk_rd("divu_lo", OP_MFLO, 32'h7FFF_FFFC);

    issue(OP_MTHI, 32'h0000_AAAA, 32'h0);
    chk("mthi_busy", {31'h0, busy}, 32'h0);
    chk_rd("mthi_hi", OP_MFHI, 32'h0000_AAAA);
    issue(OP_MTLO, 32'h0000_1234, 32'h0);
    chk_rd("mtlo_lo", OP_MFLO, 32'h0000_1234);
    chk_rd("mtlo_hi", OP_MFHI, 32'h0000_AAAA);

    issue(OP_MULT, 32'd3, 32'd4);
    chk_rd("nobypass_lo", OP_MFLO, 32'h0000_1234);
    issue(OP_MTLO, 32'h0000_DEAD, 32'h0);
    chk_rd("ign_mtlo", OP_MFLO, 32'h0000_1234);
    issue(OP_MULT, 32'd100, 32'd100);
    busy_cycles(n);
    chk("ign_busy", n, 3);
    chk_rd("ign_hi", OP_MFHI, 32'h0);
    chk_rd("ign_lo", OP_MFLO, 32'd12);

    issue(OP_DIV, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_mid_busy", {31'h0, busy}, 32'h0);
    chk_rd("rst_mid_hi", OP_MFHI, 32'h0);
    chk_rd("rst_mid_lo", OP_MFLO, 32'h0);
    #1;
    reset = 1'b1;
    repeat (15) @(negedge clk);
    chk("rst_after_busy", {31'h0, busy}, 32'h0);
    chk_rd("rst_after_hi", OP_MFHI, 32'h0);
    chk_rd("rst_after_lo", OP_MFLO, 32'h0);

    issue(OP_MTHI, 32'h0000_0005, 32'h0);
    chk_rd("nonmf_rdata", OP_MULT, 32'h0);
    chk_rd("post_mthi", OP_MFHI, 32'h0000_0005);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got time %0t expected completion", $time);
    $fatal(1);
  end

endmodule
